paralelo_serial_n: RTL and testbench
====================================

PARALELO_SERIAL_N -- requirements
Module: paralelo_serial_n

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning word width in bits, legal range 2..32.
REQ-002 SHALL have parameter IDLE_WORD, default 8'hBC, width DATA_W, meaning the idle/comma word sent when no data is accepted.
REQ-003 SHALL have parameter SYNC_FRAMES, default 4, meaning the number of idle frames forced after reset, legal range 1..255.
REQ-004 SHALL have parameter MSB_FIRST, default 1, meaning 1 = MSB transmitted first and 0 = LSB transmitted first.
REQ-005 SHALL have port clk8f, input, 1 bit: serial bit clock; one bit per rising edge.
REQ-006 SHALL have port reset_L, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port in_data, input, DATA_W bits: parallel word.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data holds a word to send.
REQ-009 SHALL have port tx_en, input, 1 bit: permits data acceptance while in RUN.
REQ-010 SHALL have port in_ready, output, 1 bit: a word is accepted on the current edge when in_valid && in_ready.
REQ-011 SHALL have port serial, output, 1 bit: registered serial line.
REQ-012 SHALL have port frame_start, output, 1 bit: serial currently carries bit position 0 of a frame.
REQ-013 SHALL have port sending_data, output, 1 bit: the current frame is a data frame, not an idle frame.

Function
REQ-014 SHALL keep a bit counter cnt in the range 0..DATA_W-1 that wraps; cnt is the position of the bit currently on serial and increments on every edge after reset.
REQ-015 SHALL treat the edge where cnt==DATA_W-1 as the frame boundary: load the next word, drive its first bit on serial, and set cnt to 0.
REQ-016 SHALL load in_data at a frame boundary when in_valid && in_ready, and otherwise SHALL load IDLE_WORD.
REQ-017 SHALL drive the remaining bits of the loaded word on the following DATA_W-1 edges, in the order set by MSB_FIRST.
REQ-018 SHALL leave frame contents unaffected by changes to in_data, in_valid or tx_en after the word is loaded.
REQ-019 SHALL drive in_ready combinationally as (state==RUN && tx_en && cnt==DATA_W-1); in_ready is never high at any other cnt value.
REQ-020 SHALL register frame_start, high exactly when cnt==0.
REQ-021 SHALL register sending_data, set at every frame boundary: 1 if a data word was loaded, 0 if IDLE_WORD was loaded.
REQ-022 SHALL implement states SYNC and RUN only; the reset state is SYNC.
REQ-023 SHALL, in SYNC, count each idle frame loaded; on the boundary edge that loads the SYNC_FRAMES-th idle frame, the state SHALL become RUN.
REQ-024 SHALL hold RUN until reset; tx_en low SHALL only suppress in_ready, giving continuous idle frames.
REQ-025 SHALL produce a continuous bit stream with no gaps between back-to-back data frames and no partial frames.
REQ-026 SHALL not accept a word in SYNC even if in_valid is high.
REQ-027 SHALL have a latency of 1 edge: the accepting edge drives the word's first bit on serial.

Reset
REQ-028 SHALL, while reset_L is low, immediately force serial=0, frame_start=0, sending_data=0, in_ready=0, cnt=DATA_W-1, the sync counter to 0, and state to SYNC.
REQ-029 SHALL load the first idle frame on the first rising edge after reset_L rises.
REQ-030 SHALL, on reset during a data frame, abandon that frame without completing it, and SHALL restart with the full SYNC_FRAMES sequence.

Verification (DATA_W=8, IDLE_WORD=8'hBC, SYNC_FRAMES=4, MSB_FIRST=1 unless stated)
REQ-031 Bench SHALL cover: release reset with in_valid=0 -> serial repeats 1,0,1,1,1,1,0,0; frame_start high every 8th cycle; in_ready first high on bit 7 of the 4th frame.
REQ-032 Bench SHALL cover: in_valid=1 with in_data=8'hA5 from reset -> frames 1-4 are 8'hBC; frame 5 is 1,0,1,0,0,1,0,1 with sending_data=1 during it.
REQ-033 Bench SHALL cover: back-to-back words 8'h01, 8'hFF, 8'h00, each presented on its in_ready cycle -> 24 contiguous data bits, then 8'hBC.
REQ-034 Bench SHALL cover: in_valid or tx_en dropped at bit 3 of a data frame -> that frame completes unchanged, the next frame is 8'hBC, and sending_data=0.
REQ-035 Bench SHALL cover: reset_L low at bit 4 of a data frame -> outputs go to 0 without waiting for a clock edge; after release, 4 idle frames are sent before in_ready.
REQ-036 Bench SHALL cover: DATA_W=10, IDLE_WORD=10'h17C, MSB_FIRST=0, word 10'h2AA -> idle bits 0,0,1,1,1,1,1,0,1,0, then data bits 0,1,0,1,0,1,0,1,0,1.

Source files
------------

// File: rtl/paralelo_serial_n.sv
// Parallel-to-serial framer: one bit per clk8f edge, fixed-length frames,
// idle/comma word whenever no data is accepted, forced idle sync after reset.
module paralelo_serial_n #(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(8'hBC),
  parameter int                SYNC_FRAMES = 4,
  parameter int                MSB_FIRST   = 1
) (
  input  logic              clk8f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              tx_en,
  output logic              in_ready,
  output logic              serial,
  output logic              frame_start,
  output logic              sending_data
);

  localparam int            CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_sync, w_sync_nxt;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              w_boundary;
  logic              w_accept;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_src;

  // cnt holds the position of the bit currently on the line; the last
  // position is the edge where the next frame gets loaded.
  assign w_boundary = (r_cnt == LAST);
  assign in_ready   = (r_state == RUN) && tx_en && w_boundary;
  assign w_accept   = in_valid && in_ready;
  assign w_word     = w_accept ? in_data : IDLE_WORD;
  // On a boundary the fresh word feeds the line, otherwise the remaining bits.
  assign w_src      = w_boundary ? w_word : r_shift;

  // State register for the SYNC/RUN sequencer and its idle-frame counter.
  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= SYNC;
      r_sync  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= w_sync_nxt;
    end
  end

  // Next state: count idle frames loaded in SYNC; RUN is sticky until reset.
  always_comb begin
    w_state_nxt = r_state;
    w_sync_nxt  = r_sync;
    if (r_state == SYNC && w_boundary) begin
      w_sync_nxt = r_sync + 8'd1;
      if (r_sync == 8'(SYNC_FRAMES - 1)) w_state_nxt = RUN;
    end
  end

  // Bit position counter, wrapping at the frame boundary.
  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L)        r_cnt <= LAST;
    else if (w_boundary) r_cnt <= '0;
    else                 r_cnt <= r_cnt + CW'(1);
  end

  // Serializer: drive one bit per edge and shift the rest toward the output end.
  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      serial  <= 1'b0;
      r_shift <= '0;
    end else if (MSB_FIRST != 0) begin
      serial  <= w_src[DATA_W-1];
      r_shift <= w_src << 1;
    end else begin
      serial  <= w_src[0];
      r_shift <= w_src >> 1;
    end
  end

  // Frame flags: start marks bit 0, sending_data tags the whole frame at load.
  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      frame_start  <= 1'b0;
      sending_data <= 1'b0;
    end else begin
      frame_start <= w_boundary;
      if (w_boundary) sending_data <= w_accept;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_n.sv
// Self-checking bench for paralelo_serial_n: frame-level reference model plus
// directed scenarios and randomized traffic; a second instance covers 10-bit LSB-first.
module tb_paralelo_serial_n;

  localparam int W = 8;

  logic         clk8f = 1'b0;
  logic         reset_L = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         tx_en = 1'b1;
  logic         in_ready, serial, frame_start, sending_data;

  logic [9:0]   in_data2 = '0;
  logic         in_valid2 = 1'b0;
  logic         tx_en2 = 1'b1;
  logic         in_ready2, serial2, frame_start2, sending_data2;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state (frame-level view of the line)
  int           m_pos;
  int           m_loaded;
  bit           m_run;
  logic [W-1:0] m_frame;
  logic         m_ser, m_fs, m_sd, exp_rdy;

  // observed values
  logic obs_ser, obs_fs, obs_sd, obs_rdy;
  logic obs_ser2, obs_sd2;

  paralelo_serial_n dut (
    .clk8f(clk8f), .reset_L(reset_L), .in_data(in_data), .in_valid(in_valid),
    .tx_en(tx_en), .in_ready(in_ready), .serial(serial),
    .frame_start(frame_start), .sending_data(sending_data)
  );

  paralelo_serial_n #(.DATA_W(10), .IDLE_WORD(10'h17C), .SYNC_FRAMES(4), .MSB_FIRST(0)) dut10 (
    .clk8f(clk8f), .reset_L(reset_L), .in_data(in_data2), .in_valid(in_valid2),
    .tx_en(tx_en2), .in_ready(in_ready2), .serial(serial2),
    .frame_start(frame_start2), .sending_data(sending_data2)
  );

  always #5 clk8f = ~clk8f;

  task automatic model_reset();
    m_pos = W - 1; m_loaded = 0; m_run = 0; m_frame = '0;
    m_ser = 0; m_fs = 0; m_sd = 0; exp_rdy = 0;
  endtask

  // Advance one bit time: sample in_ready before the edge, update the model
  // at the edge, sample registered outputs just after it.
  task automatic tick();
    bit acc;
    @(negedge clk8f);
    obs_rdy = in_ready;
    exp_rdy = m_run && tx_en && (m_pos == W - 1);
    @(posedge clk8f);
    if (m_pos == W - 1) begin
      acc     = exp_rdy && in_valid;
      m_frame = acc ? in_data : 8'hBC;
      m_sd    = acc;
      if (!m_run) begin
        m_loaded++;
        if (m_loaded == 4) m_run = 1;
      end
      m_pos = 0;
    end else begin
      m_pos++;
    end
    m_ser = m_frame[W-1-m_pos];
    m_fs  = (m_pos == 0);
    #1;
    obs_ser  = serial;  obs_fs = frame_start; obs_sd = sending_data;
    obs_ser2 = serial2; obs_sd2 = sending_data2;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk8f);
    #1 reset_L = 1'b1;
  endtask

  task automatic align(output bit ok);
    for (int k = 0; k < 2*W && m_pos != W - 1; k++) tick();
    ok = (m_pos == W - 1);
  endtask

  task automatic test_reset();
    reset_L = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    #2;
    n_tests++;
    if ({serial, frame_start, sending_data, in_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=0000", {serial, frame_start, sending_data, in_ready});
    end
    n_tests++;
    if ({serial2, frame_start2, sending_data2, in_ready2} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs_w10 got=%b want=0000", {serial2, frame_start2, sending_data2, in_ready2});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_idle();
    logic [7:0] bc = 8'hBC;
    do_reset();
    in_valid = 1'b0; tx_en = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      tick();
      n_tests++;
      if ({obs_ser, obs_fs, obs_sd, obs_rdy} !== {m_ser, m_fs, m_sd, exp_rdy}) begin
        n_fail++; $display("FAIL idle_model i=%0d got=%b want=%b", i, {obs_ser, obs_fs, obs_sd, obs_rdy}, {m_ser, m_fs, m_sd, exp_rdy});
      end
      if (i < 32) begin
        n_tests++;
        if ({obs_ser, obs_fs} !== {bc[7 - (i % 8)], 1'((i % 8) == 0)}) begin
          n_fail++; $display("FAIL idle_pattern i=%0d got=%b want=%b", i, {obs_ser, obs_fs}, {bc[7 - (i % 8)], 1'((i % 8) == 0)});
        end
      end
      n_tests++;
      if (obs_rdy !== 1'(i == 32)) begin
        n_fail++; $display("FAIL idle_ready i=%0d got=%b want=%b", i, obs_rdy, 1'(i == 32));
      end
    end
  endtask

  task automatic test_first_data();
    logic [7:0] bc = 8'hBC;
    logic [7:0] a5 = 8'hA5;
    logic       want;
    reset_L = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 32) in_valid = 1'b0;
      want = (i < 32) ? bc[7 - (i % 8)] : a5[7 - (i - 32)];
      n_tests++;
      if ({obs_ser, obs_sd} !== {want, 1'(i >= 32)}) begin
        n_fail++; $display("FAIL first_data i=%0d got=%b want=%b", i, {obs_ser, obs_sd}, {want, 1'(i >= 32)});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [3] = '{8'h01, 8'hFF, 8'h00};
    logic [23:0] got = '0;
    logic [7:0]  tail = '0;
    bit ok;
    in_valid = 1'b0;
    align(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_align got=timeout want=boundary"); end
    for (int w = 0; w < 3; w++) begin
      in_valid = 1'b1; in_data = words[w];
      for (int b = 0; b < W; b++) begin
        tick();
        if (b == 0) begin
          in_valid = 1'b0; in_data = 8'h5A;
          n_tests++;
          if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ready w=%0d got=%b want=1", w, obs_rdy); end
        end
        got = {got[22:0], obs_ser};
        n_tests++;
        if (obs_sd !== 1'b1) begin n_fail++; $display("FAIL b2b_sd w=%0d b=%0d got=%b want=1", w, b, obs_sd); end
      end
    end
    n_tests++;
    if (got !== 24'h01FF00) begin n_fail++; $display("FAIL b2b_bits got=%h want=01ff00", got); end
    for (int b = 0; b < W; b++) begin tick(); tail = {tail[6:0], obs_ser}; end
    n_tests++;
    if ({tail, obs_sd} !== {8'hBC, 1'b0}) begin n_fail++; $display("FAIL b2b_tail got=%h/%b want=bc/0", tail, obs_sd); end
  endtask

  task automatic test_drop();
    logic [7:0] got, tail;
    bit ok;
    for (int mode = 0; mode < 2; mode++) begin
      in_valid = 1'b0; tx_en = 1'b1;
      align(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL drop_align mode=%0d got=timeout want=boundary", mode); end
      in_valid = 1'b1; in_data = 8'hC6; got = '0;
      for (int b = 0; b < W; b++) begin
        tick();
        if (b == 3) begin
          if (mode == 0) in_valid = 1'b0; else tx_en = 1'b0;
          in_data = 8'h3C;
        end
        got = {got[6:0], obs_ser};
      end
      n_tests++;
      if (got !== 8'hC6) begin n_fail++; $display("FAIL drop_frame mode=%0d got=%h want=c6", mode, got); end
      tail = '0;
      for (int b = 0; b < W; b++) begin tick(); tail = {tail[6:0], obs_ser}; end
      n_tests++;
      if ({tail, obs_sd} !== {8'hBC, 1'b0}) begin n_fail++; $display("FAIL drop_next mode=%0d got=%h/%b want=bc/0", mode, tail, obs_sd); end
      in_valid = 1'b0; tx_en = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int first;
    in_valid = 1'b0;
    align(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rmid_align got=timeout want=boundary"); end
    in_valid = 1'b1; in_data = 8'hFF;
    for (int b = 0; b <= 4; b++) tick();
    n_tests++;
    if ({obs_ser, obs_sd} !== 2'b11) begin n_fail++; $display("FAIL rmid_pre got=%b want=11", {obs_ser, obs_sd}); end
    #2 reset_L = 1'b0;
    #1;
    n_tests++;
    if ({serial, frame_start, sending_data, in_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_async got=%b want=0000", {serial, frame_start, sending_data, in_ready});
    end
    do_reset();
    first = -1;
    for (int k = 0; k < 100 && first < 0; k++) begin
      tick();
      if (obs_rdy) first = k;
      else begin
        n_tests++;
        if (obs_sd !== 1'b0) begin n_fail++; $display("FAIL rmid_sync_sd k=%0d got=%b want=0", k, obs_sd); end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (first != 32) begin n_fail++; $display("FAIL rmid_ready_cycle got=%0d want=32", first); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      tx_en    = ($urandom_range(0, 9) < 8);
      in_data  = W'($urandom);
      tick();
      n_tests++;
      if ({obs_ser, obs_fs, obs_sd, obs_rdy} !== {m_ser, m_fs, m_sd, exp_rdy}) begin
        n_fail++; $display("FAIL random i=%0d got=%b want=%b", i, {obs_ser, obs_fs, obs_sd, obs_rdy}, {m_ser, m_fs, m_sd, exp_rdy});
      end
    end
    in_valid = 1'b0; tx_en = 1'b1;
  endtask

  task automatic test_w10();
    logic [9:0] v_idle = '0;
    logic [9:0] v_data = '0;
    reset_L = 1'b0;
    in_valid2 = 1'b1; in_data2 = 10'h2AA; tx_en2 = 1'b1;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 40) in_valid2 = 1'b0;
      // LSB-first: bit i of the word appears on tick i of the frame
      if (i < 10) v_idle[i] = obs_ser2;
      if (i >= 40) begin
        v_data[i-40] = obs_ser2;
        n_tests++;
        if (obs_sd2 !== 1'b1) begin n_fail++; $display("FAIL w10_sd i=%0d got=%b want=1", i, obs_sd2); end
      end
    end
    n_tests++;
    if (v_idle !== 10'h17C) begin n_fail++; $display("FAIL w10_idle got=%h want=17c", v_idle); end
    n_tests++;
    if (v_data !== 10'h2AA) begin n_fail++; $display("FAIL w10_data got=%h want=2aa", v_data); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_first_data();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_random();
    test_w10();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
